// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
//   Groups the byte-side handshake and the serial-side strobe signals of the
//   bit serializer into one bundle.
//
//   Signals:
//     data_in   [WIDTH]  parallel word offered by the source
//     valid_in           data_in is valid
//     ready_out          serializer can accept a word this edge
//     status_in          deserializer ready flag (asynchronous to clock)
//     data_out           serial bit towards the deserializer
//     write_out          bit strobe towards the deserializer
//     busy_out           serializer is working on a word
//
//   Modports:
//     master : byte source / deserializer side (drives data_in, valid_in, status_in)
//     slave  : the serializer itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             status_in;
  logic             data_out;
  logic             write_out;
  logic             busy_out;

  modport master (
    output data_in, valid_in, status_in,
    input  ready_out, data_out, write_out, busy_out
  );

  modport slave (
    input  data_in, valid_in, status_in,
    output ready_out, data_out, write_out, busy_out
  );
endinterface

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Accepts parallel words over a valid/ready handshake and emits them
//   MSB-first as a strobed serial stream (data_out + write_out pulses) for a
//   downstream deserializer. A new word is only started while the
//   deserializer's status flag (synchronized into this clock domain) is high.
//
//   Per bit: data_out set up for SETUP_CYCLES, write_out high for
//   HIGH_CYCLES, then low for LOW_CYCLES. After the last bit the line idles
//   for GAP_CYCLES before another word may be accepted.
//
//   Configuration macro:
//     SER_PARITY_EN  when defined, an even-parity bit (^data) follows the LSB
//                    with identical timing (WIDTH+1 bits per word).
//
//   Ports:
//     clock  in  single clock, rising edge
//     reset  in  asynchronous, active-low (0 = reset)
//     bus    bit_serializer_if.slave (data_in, valid_in, ready_out,
//            status_in, data_out, write_out, busy_out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bit_serializer #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 10,
  parameter int LOW_CYCLES   = 10,
  parameter int GAP_CYCLES   = 300
) (
  input logic            clock,
  input logic            reset,
  bit_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam int MAX_SH  = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
  localparam int MAX_LG  = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_SH > MAX_LG) ? MAX_SH : MAX_LG;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam int BW      = $clog2(NBITS + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LAST   = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shifted;
  logic [NBITS-1:0] load_word;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic [1:0]       status_sync;
  logic             status_s;
  logic             ser_bit;
  logic             strobe;
  logic             ready;
  logic             accept;

  // Two-flop synchronizer: status_in comes from the deserializer's clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_sync <= 2'b00;
    end else begin
      status_sync <= {status_sync[0], bus.status_in};
    end
  end

  assign status_s = status_sync[1];

  // The parity bit rides at the bottom of the shift register so it leaves last.
`ifdef SER_PARITY_EN
  assign load_word = {bus.data_in, ^bus.data_in};
`else
  assign load_word = bus.data_in;
`endif

  assign shifted = shreg << 1;
  assign ready   = (state == IDLE) && status_s;
  assign accept  = bus.valid_in && ready;

  // data_out and write_out are registered and updated on the same edge as the
  // state change, so each phase boundary is exact to the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      ser_bit <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= load_word;
            ser_bit <= load_word[NBITS-1];
            bit_cnt <= '0;
            cyc_cnt <= '0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (cyc_cnt == SETUP_LAST) begin
            cyc_cnt <= '0;
            strobe  <= 1'b1;
            state   <= HIGH;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (cyc_cnt == HIGH_LAST) begin
            cyc_cnt <= '0;
            strobe  <= 1'b0;
            state   <= LOW;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        LOW: begin
          if (cyc_cnt == LOW_LAST) begin
            cyc_cnt <= '0;
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              ser_bit <= 1'b0;
              state   <= GAP;
            end else begin
              ser_bit <= shifted[NBITS-1];
              state   <= SETUP;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        GAP: begin
          if (cyc_cnt == GAP_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          cyc_cnt <= '0;
          ser_bit <= 1'b0;
          strobe  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_out = ready;
  assign bus.busy_out  = (state != IDLE);
  assign bus.data_out  = ser_bit;
  assign bus.write_out = strobe;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Directed self-checking bench for bit_serializer with default parameters
//   (WIDTH=8, S=2, H=10, L=10, GAP=300). A negedge monitor logs accepts,
//   write_out rising edges with the bit on data_out, and ready_out rises; the
//   directed sequence compares those logs against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int BIT_PERIOD = 22;

  logic clock;
  logic reset;

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  bit_serializer #(
    .WIDTH(WIDTH),
    .SETUP_CYCLES(2),
    .HIGH_CYCLES(10),
    .LOW_CYCLES(10),
    .GAP_CYCLES(300)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   accept_cnt  = 0;
  int   accept_edge = 0;
  int   rise_n      = 0;
  int   rise_edge [16];
  logic rise_bit  [16];
  int   ready_rises = 0;
  int   ready_edge  = 0;
  int   glitches    = 0;
  logic last_bit    = 1'b0;
  logic prev_wr     = 1'b0;
  logic prev_rdy    = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // Monitor: sampled mid-cycle; inputs only change 1ns after rising edges.
  always @(negedge clock) begin
    if (bus.valid_in && bus.ready_out) begin
      accept_edge = cyc + 1;
      accept_cnt  = accept_cnt + 1;
    end
    if (bus.write_out && !prev_wr) begin
      if (rise_n < 16) begin
        rise_bit[rise_n]  = bus.data_out;
        rise_edge[rise_n] = cyc;
      end
      rise_n   = rise_n + 1;
      last_bit = bus.data_out;
    end else if (bus.write_out && (bus.data_out !== last_bit)) begin
      glitches = glitches + 1;
    end
    if (bus.ready_out && !prev_rdy) begin
      ready_edge  = cyc;
      ready_rises = ready_rises + 1;
    end
    prev_wr  = bus.write_out;
    prev_rdy = bus.ready_out;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [15:0] exp_word(logic [7:0] d);
`ifdef SER_PARITY_EN
    return {7'b0, d, ^d};
`else
    return {8'b0, d};
`endif
  endfunction

  function automatic logic [15:0] got_word();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < rise_n && i < 16; i++) w = {w[14:0], rise_bit[i]};
    return w;
  endfunction

  task automatic wait_accept(string tag, int start);
    for (int i = 0; i < 50 && accept_cnt == start; i++) tick(1);
    check_output(tag, 32'(accept_cnt != start), 32'd1);
    bus.valid_in = 1'b0;
  endtask

  task automatic apply_stimulus(logic [7:0] d, string tag);
    int start;
    start        = accept_cnt;
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    wait_accept(tag, start);
  endtask

  task automatic wait_ready(string tag);
    int start;
    start = ready_rises;
    for (int i = 0; i < 700 && ready_rises == start; i++) tick(1);
    check_output(tag, 32'(ready_rises != start), 32'd1);
  endtask

  initial begin
    int r;
    int n;
    int start;

    reset         = 1'b0;
    bus.data_in   = 8'hFF;
    bus.valid_in  = 1'b1;
    bus.status_in = 1'b1;

    // 1: reset held with active inputs
    tick(3);
    bus.data_in = 8'h5A;
    tick(3);
    @(negedge clock);
    check_output("rst_data_out",  32'(bus.data_out),  32'd0);
    check_output("rst_write_out", 32'(bus.write_out), 32'd0);
    check_output("rst_ready_out", 32'(bus.ready_out), 32'd0);
    check_output("rst_busy_out",  32'(bus.busy_out),  32'd0);
    check_output("rst_no_accept", 32'(accept_cnt),    32'd0);

    @(posedge clock);
    #1;
    bus.valid_in = 1'b0;
    reset        = 1'b1;
    tick(3);
    check_output("post_rst_ready", 32'(bus.ready_out), 32'd1);

    // 2: 8'hA5 end to end with timing
    rise_n = 0;
    apply_stimulus(8'hA5, "a5_accept");
    wait_ready("a5_ready_back");
    check_output("a5_count",      32'(rise_n), 32'(NB));
    check_output("a5_bits",       32'(got_word()), 32'(exp_word(8'hA5)));
    check_output("a5_first_rise", 32'(rise_edge[0] - accept_edge), 32'd2);
    check_output("a5_last_rise",  32'(rise_edge[NB-1] - rise_edge[0]), 32'((NB - 1) * BIT_PERIOD));
    check_output("a5_ready_lat",  32'(ready_edge - accept_edge), 32'(NB * BIT_PERIOD + 300));

    // 3: status low blocks accept; raising it lets the held word in
    bus.status_in = 1'b0;
    tick(3);
    check_output("st0_ready", 32'(bus.ready_out), 32'd0);
    rise_n       = 0;
    start        = accept_cnt;
    bus.data_in  = 8'h81;
    bus.valid_in = 1'b1;
    tick(20);
    check_output("st0_no_accept",  32'(accept_cnt), 32'(start));
    check_output("st0_no_strobes", 32'(rise_n), 32'd0);
    r             = cyc;
    bus.status_in = 1'b1;
    wait_accept("81_accept", start);
    check_output("81_sync_lat", 32'((accept_edge - r == 2) || (accept_edge - r == 3)), 32'd1);
    wait_ready("81_ready_back");
    check_output("81_count", 32'(rise_n), 32'(NB));
    check_output("81_bits",  32'(got_word()), 32'(exp_word(8'h81)));

    // 4: status dropped mid-word does not cut the word short
    rise_n = 0;
    apply_stimulus(8'h3C, "3c_accept");
    for (int i = 0; i < 200 && rise_n < 4; i++) tick(1);
    bus.status_in = 1'b0;
    for (int i = 0; i < 700 && bus.busy_out; i++) tick(1);
    check_output("3c_done",  32'(bus.busy_out), 32'd0);
    check_output("3c_count", 32'(rise_n), 32'(NB));
    check_output("3c_bits",  32'(got_word()), 32'(exp_word(8'h3C)));
    tick(3);
    check_output("3c_ready_gated", 32'(bus.ready_out), 32'd0);
    start        = accept_cnt;
    bus.data_in  = 8'h55;
    bus.valid_in = 1'b1;
    tick(20);
    check_output("3c_next_waits", 32'(accept_cnt), 32'(start));

    // 5: reset during HIGH of bit 5
    rise_n        = 0;
    bus.status_in = 1'b1;
    wait_accept("55_accept", start);
    for (int i = 0; i < 300 && rise_n < 6; i++) tick(1);
    tick(3);
    check_output("55_in_high", 32'(bus.write_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("abort_write_out", 32'(bus.write_out), 32'd0);
    check_output("abort_data_out",  32'(bus.data_out),  32'd0);
    check_output("abort_busy_out",  32'(bus.busy_out),  32'd0);
    tick(3);
    reset = 1'b1;
    n     = rise_n;
    start = accept_cnt;
    tick(40);
    check_output("abort_no_resume", 32'(rise_n), 32'(n));
    check_output("abort_idle",      32'(bus.busy_out), 32'd0);
    check_output("abort_no_accept", 32'(accept_cnt), 32'(start));
    check_output("abort_ready",     32'(bus.ready_out), 32'd1);

    // 6: parity cases (plain words when parity is not built in)
    rise_n = 0;
    apply_stimulus(8'h07, "07_accept");
    wait_ready("07_ready_back");
    check_output("07_count", 32'(rise_n), 32'(NB));
    check_output("07_bits",  32'(got_word()), 32'(exp_word(8'h07)));
`ifdef SER_PARITY_EN
    check_output("07_parity", 32'(rise_bit[8]), 32'd1);
`endif
    rise_n = 0;
    apply_stimulus(8'h03, "03_accept");
    wait_ready("03_ready_back");
    check_output("03_count", 32'(rise_n), 32'(NB));
    check_output("03_bits",  32'(got_word()), 32'(exp_word(8'h03)));
`ifdef SER_PARITY_EN
    check_output("03_parity", 32'(rise_bit[8]), 32'd0);
`endif

    check_output("data_stable_in_high", 32'(glitches), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
